uart_tx_arbiter: RTL and testbench

//   Shares the single uart transmitter among NUM_REQ byte requesters using round-robin arbitration.

---
 rtl/uart_tx_arbiter.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart transmitter among NUM_REQ byte requesters.
// Optional start-timeout watchdog is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int GID_W          = 2,
    parameter int TIMEOUT_CYCLES = 10416
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [7:0]           uart_ctrl_in,
    output logic                 uart_tx_en,
    output logic [7:0]           uart_tx_data,
    output logic                 busy,
    output logic [GID_W-1:0]     grant_id,
    output logic                 tx_done,
    output logic                 tx_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_SENDING = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [NUM_REQ-1:0] req_ready_r, req_ready_s;
    logic               tx_en_r, tx_en_s;
    logic [7:0]         tx_data_r, tx_data_s;
    logic [GID_W-1:0]   grant_id_r, grant_id_s;
    logic               tx_done_r, tx_done_s;
    logic               tx_err_r, tx_err_s;
    logic               sending_prev_r;
    logic               sending_s;
    logic               sending_rise_s;
    logic               any_valid_s;
    logic [GID_W-1:0]   winner_s;
    logic               unused_ctrl_s;

    assign sending_s      = uart_ctrl_in[1];
    assign sending_rise_s = sending_s & ~sending_prev_r;
    assign unused_ctrl_s  = ^{uart_ctrl_in[7:2], uart_ctrl_in[0]};

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] cnt_r, cnt_s;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    // Round-robin search: the last hit in the descending scan is nearest to grant_id+1
    always_comb begin
        any_valid_s = 1'b0;
        winner_s    = {GID_W{1'b0}};
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid[(int'(grant_id_r) + k) % NUM_REQ]) begin
                any_valid_s = 1'b1;
                winner_s    = GID_W'((int'(grant_id_r) + k) % NUM_REQ);
            end else begin
                any_valid_s = any_valid_s;
            end
        end
    end

    // Next-state and next-output logic for the transfer sequencer
    always_comb begin
        state_s     = state_r;
        req_ready_s = {NUM_REQ{1'b0}};
        tx_en_s     = tx_en_r;
        tx_data_s   = tx_data_r;
        grant_id_s  = grant_id_r;
        tx_done_s   = 1'b0;
        tx_err_s    = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_s       = cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (any_valid_s) begin
                    req_ready_s = NUM_REQ'(1) << winner_s;
                    tx_en_s     = 1'b1;
                    tx_data_s   = req_data[8*int'(winner_s) +: 8];
                    grant_id_s  = winner_s;
                    state_s     = ST_START;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_s       = 16'd0;
`endif
                end else begin
                    tx_en_s = 1'b0;
                end
            end
            ST_START: begin
                // Only a fresh rise counts, so a frame already in flight is not mistaken for ours
                if (sending_rise_s) begin
                    tx_en_s = 1'b0;
                    state_s = ST_SENDING;
                end else begin
`ifdef UART_ARB_TIMEOUT_EN
                    if (cnt_r == 16'(TIMEOUT_CYCLES - 1)) begin
                        tx_en_s  = 1'b0;
                        tx_err_s = 1'b1;
                        state_s  = ST_IDLE;
                    end else begin
                        tx_en_s = 1'b1;
                        cnt_s   = cnt_r + 16'd1;
                    end
`else
                    tx_en_s = 1'b1;
`endif
                end
            end
            ST_SENDING: begin
                if (!sending_s) begin
                    tx_done_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_SENDING;
                end
            end
            default: begin
                tx_en_s = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered-output flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            req_ready_r    <= {NUM_REQ{1'b0}};
            tx_en_r        <= 1'b0;
            tx_data_r      <= 8'h00;
            grant_id_r     <= GID_W'(NUM_REQ - 1);
            tx_done_r      <= 1'b0;
            tx_err_r       <= 1'b0;
            sending_prev_r <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_r          <= 16'd0;
`endif
        end else begin
            state_r        <= state_s;
            req_ready_r    <= req_ready_s;
            tx_en_r        <= tx_en_s;
            tx_data_r      <= tx_data_s;
            grant_id_r     <= grant_id_s;
            tx_done_r      <= tx_done_s;
            tx_err_r       <= tx_err_s;
            sending_prev_r <= sending_s;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_r          <= cnt_s;
`endif
        end
    end

    assign req_ready    = req_ready_r;
    assign uart_tx_en   = tx_en_r;
    assign uart_tx_data = tx_data_r;
    assign busy         = (state_r != ST_IDLE);
    assign grant_id     = grant_id_r;
    assign tx_done      = tx_done_r;
    assign tx_err       = tx_err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter; the uart status is driven by hand.
// The start-timeout scenario runs only when UART_ARB_TIMEOUT_EN is defined.
`timescale 1ps/1ps
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  uart_ctrl_in;
    logic        uart_tx_en;
    logic [7:0]  uart_tx_data;
    logic        busy;
    logic [1:0]  grant_id;
    logic        tx_done;
    logic        tx_err;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_arbiter #(
        .NUM_REQ        (4),
        .GID_W          (2),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .uart_ctrl_in (uart_ctrl_in),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .busy         (busy),
        .grant_id     (grant_id),
        .tx_done      (tx_done),
        .tx_err       (tx_err)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".ready"}, 32'(req_ready), 32'h0);
        chk({tag, ".tx_en"}, 32'(uart_tx_en), 32'h0);
        chk({tag, ".data"}, 32'(uart_tx_data), 32'h0);
        chk({tag, ".busy"}, 32'(busy), 32'h0);
        chk({tag, ".gid"}, 32'(grant_id), 32'h3);
        chk({tag, ".done"}, 32'(tx_done), 32'h0);
        chk({tag, ".err"}, 32'(tx_err), 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        chk_reset_vals("rst");
        reset = 1'b1;
    endtask

    // One complete transfer: grant, start handshake, sending, done
    task automatic serve(input int id, input logic [7:0] data, input bit drop);
        tick();
        chk("grant.ready", 32'(req_ready), 32'(4'b0001 << id));
        chk("grant.tx_en", 32'(uart_tx_en), 32'h1);
        chk("grant.data", 32'(uart_tx_data), 32'(data));
        chk("grant.gid", 32'(grant_id), 32'(id));
        chk("grant.busy", 32'(busy), 32'h1);
        chk("grant.done", 32'(tx_done), 32'h0);
        if (drop) req_valid[id] = 1'b0;
        tick();
        chk("start.ready", 32'(req_ready), 32'h0);
        chk("start.tx_en", 32'(uart_tx_en), 32'h1);
        uart_ctrl_in = 8'h07;
        tick();
        chk("send.tx_en", 32'(uart_tx_en), 32'h0);
        chk("send.busy", 32'(busy), 32'h1);
        tick();
        tick();
        chk("send.done", 32'(tx_done), 32'h0);
        chk("send.data", 32'(uart_tx_data), 32'(data));
        uart_ctrl_in = 8'h05;
        tick();
        chk("done.pulse", 32'(tx_done), 32'h1);
        chk("done.busy", 32'(busy), 32'h0);
    endtask

    initial begin
        reset        = 1'b1;
        req_valid    = 4'b0000;
        req_data     = 32'h0;
        uart_ctrl_in = 8'h00;
        #3;
        do_reset();

        // Single request
        req_valid = 4'b0001;
        req_data  = 32'h0000_008F;
        serve(0, 8'h8F, 1'b1);
        tick();
        chk("single.done_width", 32'(tx_done), 32'h0);

        // All four valid from reset: grants 0,1,2,3
        do_reset();
        req_data  = {8'hFF, 8'h00, 8'hA5, 8'h39};
        req_valid = 4'b1111;
        serve(0, 8'h39, 1'b1);
        serve(1, 8'hA5, 1'b1);
        serve(2, 8'h00, 1'b1);
        serve(3, 8'hFF, 1'b1);

        // Requesters 1 and 3 continuously valid with grant_id=1: alternate 3,1,3,1
        req_valid = 4'b0010;
        serve(1, 8'hA5, 1'b1);
        req_valid = 4'b1010;
        serve(3, 8'hFF, 1'b0);
        serve(1, 8'hA5, 1'b0);
        serve(3, 8'hFF, 1'b0);
        serve(1, 8'hA5, 1'b0);
        req_valid = 4'b0000;

        // TX_SENDING already high on entry to START: needs a fresh rise
        uart_ctrl_in = 8'h02;
        req_data     = 32'h0000_005A;
        req_valid    = 4'b0001;
        tick();
        chk("pre.gid", 32'(grant_id), 32'h0);
        req_valid = 4'b0000;
        tick();
        tick();
        tick();
        chk("pre.tx_en_held", 32'(uart_tx_en), 32'h1);
        chk("pre.busy", 32'(busy), 32'h1);
        uart_ctrl_in = 8'h00;
        tick();
        chk("pre.tx_en_low", 32'(uart_tx_en), 32'h1);
        uart_ctrl_in = 8'h02;
        tick();
        chk("pre.tx_en_off", 32'(uart_tx_en), 32'h0);
        uart_ctrl_in = 8'h00;
        tick();
        chk("pre.done", 32'(tx_done), 32'h1);

        // Withdrawn pulse on requester 2 while busy is never granted
        req_data  = 32'h0022_0011;
        req_valid = 4'b0001;
        tick();
        chk("wd.gid", 32'(grant_id), 32'h0);
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b0000;
        chk("wd.ready", 32'(req_ready), 32'h0);
        uart_ctrl_in = 8'h02;
        tick();
        uart_ctrl_in = 8'h00;
        tick();
        chk("wd.done", 32'(tx_done), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wd.idle_ready", 32'(req_ready), 32'h0);
            chk("wd.idle_busy", 32'(busy), 32'h0);
        end

        // Reset asserted while in SENDING
        req_data  = 32'h0000_00C3;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        uart_ctrl_in = 8'h02;
        tick();
        tick();
        chk("mid.busy", 32'(busy), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("mid");
        uart_ctrl_in = 8'h00;
        tick();
        reset = 1'b1;
        tick();
        chk("mid.after_busy", 32'(busy), 32'h0);
        chk("mid.after_done", 32'(tx_done), 32'h0);
        tick();
        chk("mid.after_busy2", 32'(busy), 32'h0);

`ifdef UART_ARB_TIMEOUT_EN
        // Start timeout: tx_err 100 cycles after grant, no tx_done
        do_reset();
        uart_ctrl_in = 8'h00;
        req_data     = 32'h0000_6677;
        req_valid    = 4'b0001;
        tick();
        chk("to.gid", 32'(grant_id), 32'h0);
        req_valid = 4'b0000;
        for (int i = 1; i < 100; i++) tick();
        chk("to.err_early", 32'(tx_err), 32'h0);
        chk("to.tx_en_held", 32'(uart_tx_en), 32'h1);
        tick();
        chk("to.err", 32'(tx_err), 32'h1);
        chk("to.tx_en", 32'(uart_tx_en), 32'h0);
        chk("to.busy", 32'(busy), 32'h0);
        chk("to.done", 32'(tx_done), 32'h0);
        tick();
        chk("to.err_width", 32'(tx_err), 32'h0);
        req_valid = 4'b0011;
        serve(1, 8'h66, 1'b1);
        req_valid = 4'b0000;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
